// File: rtl/cordic_seq_pkg.sv
// Shared types and constants for the CORDIC custom-instruction sequencer.
package cordic_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [31:0] NAN_WORD_DEFAULT = 32'h7FC00000;
   localparam int          NOMINAL_LATENCY  = 5;
   localparam int          CNT_W            = 8;

endpackage

// File: rtl/cordic_result_cache.sv
// One-entry result cache keyed on the operand magnitude (cosine is even, so the sign bit is not part of the tag).
module cordic_result_cache (
   input  logic        clock,
   input  logic        aclr,
   input  logic        clk_en,
   input  logic [30:0] lookup_tag,
   output logic        hit,
   output logic [31:0] cached,
   input  logic        write,
   input  logic [30:0] write_tag,
   input  logic [31:0] write_data,
   input  logic        invalidate
);

   logic        valid_reg;
   logic [30:0] tag_reg;
   logic [31:0] data_reg;

   always_ff @(posedge clock) begin
      if (aclr) begin
         valid_reg <= 1'b0;
         tag_reg   <= '0;
         data_reg  <= '0;
      end else if (clk_en) begin
         if (invalidate) begin
            valid_reg <= 1'b0;
         end else if (write) begin
            valid_reg <= 1'b1;
            tag_reg   <= write_tag;
            data_reg  <= write_data;
         end
      end
   end

   assign hit    = valid_reg && (tag_reg == lookup_tag);
   assign cached = data_reg;

endmodule

// File: rtl/cordic_ci_sequencer.sv
// Custom-instruction front end for the unrolled CORDIC cosine core: latch, issue, qualified capture, timeout.
// Optional one-entry result cache enabled by defining CORDIC_RESULT_CACHE_EN.
module cordic_ci_sequencer
   import cordic_seq_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 15,
   parameter logic [31:0] NAN_WORD       = NAN_WORD_DEFAULT
) (
   input  logic        clock,
   input  logic        aclr,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   output logic [31:0] result,
   output logic        done,
   output logic        busy,
   output logic        error,
   output logic        core_clk_en,
   output logic        core_start,
   output logic [31:0] core_dataa,
   input  logic [31:0] core_result,
   input  logic        core_done
);

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] counter_reg, counter_next;
   logic [31:0]      result_reg, result_next;
   logic [31:0]      core_dataa_reg, core_dataa_next;
   logic             done_reg, done_next;
   logic             busy_reg, busy_next;
   logic             error_reg, error_next;
   logic             core_start_reg, core_start_next;

`ifdef CORDIC_RESULT_CACHE_EN
   logic        cache_hit;
   logic        cache_write;
   logic        cache_inval;
   logic [31:0] cache_data;

   cordic_result_cache u_cache (
      .clock      (clock),
      .aclr       (aclr),
      .clk_en     (clk_en),
      .lookup_tag (dataa[30:0]),
      .hit        (cache_hit),
      .cached     (cache_data),
      .write      (cache_write),
      .write_tag  (core_dataa_reg[30:0]),
      .write_data (core_result),
      .invalidate (cache_inval)
   );
`endif

   always_ff @(posedge clock) begin
      if (aclr) begin
         state_reg      <= IDLE;
         counter_reg    <= '0;
         result_reg     <= '0;
         core_dataa_reg <= '0;
         done_reg       <= 1'b0;
         busy_reg       <= 1'b0;
         error_reg      <= 1'b0;
         core_start_reg <= 1'b0;
      end else if (clk_en) begin
         state_reg      <= state_next;
         counter_reg    <= counter_next;
         result_reg     <= result_next;
         core_dataa_reg <= core_dataa_next;
         done_reg       <= done_next;
         busy_reg       <= busy_next;
         error_reg      <= error_next;
         core_start_reg <= core_start_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      counter_next    = counter_reg;
      result_next     = result_reg;
      core_dataa_next = core_dataa_reg;
      done_next       = 1'b0;
      error_next      = error_reg;
      core_start_next = 1'b0;
`ifdef CORDIC_RESULT_CACHE_EN
      cache_write     = 1'b0;
      cache_inval     = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (start) begin
               core_dataa_next = dataa;
               state_next      = ISSUE;
               core_start_next = 1'b1;
`ifdef CORDIC_RESULT_CACHE_EN
               if (cache_hit) begin
                  state_next      = DONE;
                  core_start_next = 1'b0;
                  done_next       = 1'b1;
                  result_next     = cache_data;
               end
`endif
            end
         end
         ISSUE: begin
            counter_next = '0;
            state_next   = WAIT;
         end
         WAIT: begin
            counter_next = counter_reg + 1'b1;
            // The core's done keeps toggling after completion; the first WAIT cycle is never trusted.
            if (core_done && (counter_reg != '0)) begin
               result_next = core_result;
               done_next   = 1'b1;
               state_next  = DONE;
`ifdef CORDIC_RESULT_CACHE_EN
               cache_write = 1'b1;
`endif
            end else if (counter_reg == TIMEOUT_LAST) begin
               // TIMEOUT_CYCLES full WAIT cycles have elapsed with no qualified done.
               result_next = NAN_WORD;
               error_next  = 1'b1;
               done_next   = 1'b1;
               state_next  = DONE;
`ifdef CORDIC_RESULT_CACHE_EN
               cache_inval = 1'b1;
`endif
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      busy_next = (state_next != IDLE);
   end

   assign result      = result_reg;
   assign done        = done_reg;
   assign busy        = busy_reg;
   assign error       = error_reg;
   assign core_clk_en = clk_en;
   assign core_start  = core_start_reg;
   assign core_dataa  = core_dataa_reg;

endmodule

// File: tb/tb_cordic_ci_sequencer.sv
// Self-checking bench for cordic_ci_sequencer with a transaction-level reference model.
// Honours CORDIC_RESULT_CACHE_EN the same way the design does.
module tb_cordic_ci_sequencer;
   import cordic_seq_pkg::*;

   localparam int          T   = 15;
   localparam logic [31:0] NAN = 32'h7FC00000;

   logic        clock = 1'b0;
   logic        aclr, clk_en, start, core_done;
   logic [31:0] dataa, core_result;
   logic [31:0] result, core_dataa;
   logic        done, busy, error, core_clk_en, core_start;

   int checks = 0;
   int passed = 0;

   // Reference model state
   logic [31:0] exp_result;
   bit          exp_error;
   bit          cache_valid;
   logic [30:0] cache_tag;
   logic [31:0] cache_data;
   logic [31:0] res_at [0:63];

   cordic_ci_sequencer #(.TIMEOUT_CYCLES(T), .NAN_WORD(NAN)) dut (
      .clock       (clock),
      .aclr        (aclr),
      .clk_en      (clk_en),
      .start       (start),
      .dataa       (dataa),
      .result      (result),
      .done        (done),
      .busy        (busy),
      .error       (error),
      .core_clk_en (core_clk_en),
      .core_start  (core_start),
      .core_dataa  (core_dataa),
      .core_result (core_result),
      .core_done   (core_done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
   endtask

   function automatic bit sched(input int n, input int f, input bit tog);
      if (f == 0 || n < f) return 1'b0;
      return tog ? (((n - f) % 2) == 0) : (n == f);
   endfunction

   task automatic model_reset();
      exp_result  = '0;
      exp_error   = 1'b0;
      cache_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      aclr = 1'b1; clk_en = 1'b1; start = 1'b0; core_done = 1'b0;
      @(negedge clock);
      aclr = 1'b0;
      model_reset();
      chk("rst_result", result, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_error", {31'h0, error}, 32'h0);
      chk("rst_core_start", {31'h0, core_start}, 32'h0);
      chk("rst_core_dataa", core_dataa, 32'h0);
   endtask

   // One request; f = cycle of first core done (0 = never), tog = keep toggling with period 2.
   task automatic run_txn(input logic [31:0] op, input int f, input bit tog, input logic [31:0] fval,
                          input int stall_pct, input int stall_at, input int stall_len);
      bit          hit, to, en;
      int          d, n, periods, stalled;
      logic [31:0] new_res;
      hit = 1'b0;
`ifdef CORDIC_RESULT_CACHE_EN
      hit = cache_valid && (op[30:0] == cache_tag);
`endif
      foreach (res_at[i]) res_at[i] = $urandom;
      if (f > 0 && f < 64) res_at[f] = fval;
      to = 1'b0;
      if (hit) begin
         d = 1;
         new_res = cache_data;
      end else begin
         d = 0;
         for (int c = 3; c <= 2 + T; c++) begin
            if (d == 0 && sched(c, f, tog)) begin
               d = c + 1;
               new_res = res_at[c];
            end
         end
         if (d == 0) begin
            d = T + 3;
            new_res = NAN;
            to = 1'b1;
         end
      end
      // Edge 0: request sampled in IDLE
      start = 1'b1; dataa = op; clk_en = 1'b1; core_done = 1'b0; core_result = $urandom;
      en = 1'b1; n = 0; periods = 0; stalled = 0;
      forever begin
         @(negedge clock);
         if (en) n++;
         periods++;
         chk("done", {31'h0, done}, {31'h0, (n == d)});
         chk("busy", {31'h0, busy}, {31'h0, (n >= 1 && n <= d)});
         chk("core_start", {31'h0, core_start}, {31'h0, (n == 1 && !hit)});
         chk("core_clk_en", {31'h0, core_clk_en}, {31'h0, clk_en});
         chk("result", result, (n >= d) ? new_res : exp_result);
         chk("error", {31'h0, error}, {31'h0, (exp_error || (to && n >= d))});
         if (!hit) chk("core_dataa", core_dataa, op);
         if (n == d) break;
         if (n == stall_at && stalled < stall_len) begin
            en = 1'b0;
            stalled++;
         end else begin
            en = (periods > 200) ? 1'b1 : ($urandom_range(99) >= stall_pct);
         end
         clk_en = en;
         start  = $urandom_range(1);
         dataa  = $urandom;
         core_done   = en ? sched(n, f, tog) : 1'($urandom_range(1));
         core_result = en ? res_at[n] : $urandom;
      end
      $display("txn op=%h f=%0d tog=%0d hit=%0d timeout=%0d done_cycle=%0d result=%h", op, f, tog, hit, to, d, result);
      clk_en = 1'b1; start = 1'b0; core_done = 1'b0;
      @(negedge clock);
      chk("idle_done", {31'h0, done}, 32'h0);
      chk("idle_busy", {31'h0, busy}, 32'h0);
      chk("idle_result", result, new_res);
      exp_result = new_res;
      exp_error  = exp_error || to;
      if (!hit) begin
         if (to) cache_valid = 1'b0;
         else begin
            cache_valid = 1'b1;
            cache_tag   = op[30:0];
            cache_data  = new_res;
         end
      end
   endtask

   task automatic reset_mid_wait();
      start = 1'b1; dataa = 32'h3F400000; clk_en = 1'b1; core_done = 1'b0;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      @(negedge clock);
      aclr = 1'b1;
      @(negedge clock);
      aclr = 1'b0;
      model_reset();
      chk("mid_rst_busy", {31'h0, busy}, 32'h0);
      chk("mid_rst_done", {31'h0, done}, 32'h0);
      chk("mid_rst_error", {31'h0, error}, 32'h0);
      chk("mid_rst_result", result, 32'h0);
      chk("mid_rst_core_dataa", core_dataa, 32'h0);
      for (int i = 0; i < 6; i++) begin
         core_done = ~core_done;
         core_result = $urandom;
         @(negedge clock);
         chk("mid_rst_no_done", {31'h0, done}, 32'h0);
         chk("mid_rst_idle", {31'h0, busy}, 32'h0);
      end
      core_done = 1'b0;
      $display("txn reset during WAIT: busy=%0d done=%0d error=%0d", busy, done, error);
   endtask

   initial begin
      logic [31:0] pool [0:3];
      aclr = 1'b1; clk_en = 1'b1; start = 1'b0; dataa = '0;
      core_done = 1'b0; core_result = '0;
      model_reset();
      do_reset();
      // Nominal request: done in cycle NOMINAL_LATENCY
      run_txn(32'h3F000000, 4, 1'b0, 32'h3F60A940, 0, -1, 0);
      // Toggling core done: only the first qualified edge counts
      run_txn(32'h3F800000, 4, 1'b1, 32'h3F0A5140, 0, -1, 0);
      run_txn(32'h40000000, 2, 1'b1, 32'hBED51200, 0, -1, 0);
      // Timeout with core done stuck low, then sticky error across a good request
      run_txn(32'h40400000, 0, 1'b0, 32'h0, 0, -1, 0);
      run_txn(32'h3E800000, 4, 1'b0, 32'h3F780000, 0, -1, 0);
      // Three-cycle enable drop in WAIT
      run_txn(32'h3E000000, 4, 1'b0, 32'h3F7E0000, 0, 3, 3);
      // Timeout boundary: done in the last WAIT cycle is still captured
      run_txn(32'h41000000, 2 + T, 1'b0, 32'h12345678, 0, -1, 0);
      reset_mid_wait();
      // Repeated operand and its negation
      run_txn(32'h3F000000, 4, 1'b0, 32'h3F60A940, 0, -1, 0);
      run_txn(32'h3F000000, 4, 1'b0, 32'h3F60A940, 0, -1, 0);
      run_txn(32'hBF000000, 4, 1'b0, 32'h3F60A940, 0, -1, 0);
      pool[0] = 32'h3F000000; pool[1] = 32'hBF800000;
      pool[2] = 32'h3F800000; pool[3] = $urandom;
      for (int k = 0; k < 30; k++) begin
         run_txn(pool[$urandom_range(3)], $urandom_range(20), 1'($urandom_range(1)), $urandom,
                 ($urandom_range(1) == 1) ? 25 : 0, -1, 0);
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
